pfd_tdc: RTL and testbench

Parametrised digital phase-frequency detector with a built-in time-to-digital counter, for the PLL/DLL loop front-end. It synchronises clk_ref and clk_fb into the clk domain and produces up/down pulses. Each comparison also yields a signed, saturating phase-error count in clk cycles, cycle-slip flagging and a lock indicator. The error word feeds the digital loop filter directly, so no external pulse-width integration is needed.

---
 rtl/pfd_tdc.sv | 212 +++++++++++++++++++++
 tb/tb_pfd_tdc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pfd_tdc.sv
// Digital phase-frequency detector with a built-in time-to-digital counter, cycle-slip flag and lock detect.
// Optional feature: define PFD_DEADZONE_EN to report err=0 for comparisons whose magnitude is <= DEADZONE.
module pfd_tdc #(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 12,
   parameter int LOCK_TOL    = 4,
   parameter int LOCK_CNT    = 16,
   parameter int DEADZONE    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clk_ref,
   input  logic             clk_fb,
   output logic             up,
   output logic             down,
   output logic             err_valid,
   output logic [ERR_W-1:0] err,
   output logic             locked,
   output logic             cycle_slip
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

`ifdef PFD_DEADZONE_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   localparam logic [ERR_W-1:0] CNT_MAX     = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic [ERR_W-1:0] CNT_ONE     = ERR_W'(1);
   localparam logic [ERR_W-1:0] DZ_MAG      = ERR_W'(DEADZONE);
   localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_CNT);

   logic [SYNC_STAGES-1:0] ref_sync_q;
   logic [SYNC_STAGES-1:0] fb_sync_q;
   logic                   ref_dly_q;
   logic                   fb_dly_q;
   logic                   ref_edge_s;
   logic                   fb_edge_s;

   state_t                 state_q, state_d;
   logic [ERR_W-1:0]       cnt_q, cnt_d;
   logic                   close_s;
   logic                   close_neg_s;
   logic                   slip_s;
   logic [ERR_W-1:0]       close_mag_s;
   logic [ERR_W-1:0]       mag_s;
   logic [ERR_W-1:0]       err_next_s;

   logic                   up_q, down_q, err_valid_q, slip_q, locked_q;
   logic [ERR_W-1:0]       err_q;
   logic [7:0]             lock_cnt_q;
   logic [ERR_W-1:0]       err_abs_s;
   logic                   in_tol_s;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      if (v >= CNT_MAX) begin
         return CNT_MAX;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   // Input synchronisers plus one delay flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync_q <= '0;
         fb_sync_q  <= '0;
         ref_dly_q  <= 1'b0;
         fb_dly_q   <= 1'b0;
      end else begin
         ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], clk_ref};
         fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], clk_fb};
         ref_dly_q  <= ref_sync_q[SYNC_STAGES-1];
         fb_dly_q   <= fb_sync_q[SYNC_STAGES-1];
      end
   end

   assign ref_edge_s = ref_sync_q[SYNC_STAGES-1] & ~ref_dly_q;
   assign fb_edge_s  = fb_sync_q[SYNC_STAGES-1] & ~fb_dly_q;

   // Comparison state machine next-state, counter and close/slip decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      close_s     = 1'b0;
      close_neg_s = 1'b0;
      slip_s      = 1'b0;
      close_mag_s = '0;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ref_edge_s && fb_edge_s) begin
                  close_s = 1'b1;
               end else if (ref_edge_s) begin
                  state_d = ST_UP;
                  cnt_d   = CNT_ONE;
               end else if (fb_edge_s) begin
                  state_d = ST_DOWN;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_UP: begin
               if (fb_edge_s) begin
                  close_s     = 1'b1;
                  close_mag_s = cnt_q;
                  // A simultaneous ref edge opens the next comparison straight away.
                  if (ref_edge_s) begin
                     state_d = ST_UP;
                     cnt_d   = CNT_ONE;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d  = sat_inc(cnt_q);
                  slip_s = ref_edge_s;
               end
            end
            ST_DOWN: begin
               if (ref_edge_s) begin
                  close_s     = 1'b1;
                  close_neg_s = 1'b1;
                  close_mag_s = cnt_q;
                  if (fb_edge_s) begin
                     state_d = ST_DOWN;
                     cnt_d   = CNT_ONE;
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d  = sat_inc(cnt_q);
                  slip_s = fb_edge_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign mag_s      = (DZ_EN && (close_mag_s <= DZ_MAG)) ? '0 : close_mag_s;
   assign err_next_s = close_neg_s ? (~mag_s + CNT_ONE) : mag_s;

   // State, counter and registered detector outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
         err_valid_q <= 1'b0;
         err_q       <= '0;
         slip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         up_q        <= (state_d == ST_UP);
         down_q      <= (state_d == ST_DOWN);
         err_valid_q <= close_s;
         slip_q      <= slip_s;
         if (close_s) begin
            err_q <= err_next_s;
         end else begin
            err_q <= err_q;
         end
      end
   end

   assign err_abs_s = err_q[ERR_W-1] ? (~err_q + CNT_ONE) : err_q;
   assign in_tol_s  = (int'(err_abs_s) <= LOCK_TOL);

   // Lock qualification over consecutive in-tolerance results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_q <= 8'd0;
         locked_q   <= 1'b0;
      end else if (!en || slip_q || (err_valid_q && !in_tol_s)) begin
         lock_cnt_q <= 8'd0;
         locked_q   <= 1'b0;
      end else begin
         if (err_valid_q && (lock_cnt_q < LOCK_TARGET)) begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
         end else begin
            lock_cnt_q <= lock_cnt_q;
         end
         locked_q <= (lock_cnt_q >= LOCK_TARGET);
      end
   end

   assign up         = up_q;
   assign down       = down_q;
   assign err_valid  = err_valid_q;
   assign err        = err_q;
   assign locked     = locked_q;
   assign cycle_slip = slip_q;

endmodule

// File: tb/tb_pfd_tdc.sv
// Directed self-checking bench for pfd_tdc (ERR_W=6, LOCK_TOL=2, LOCK_CNT=4, DEADZONE=1).
module tb_pfd_tdc;

   logic       clk = 1'b0;
   logic       rst_n, en, clk_ref, clk_fb;
   logic       up, down, err_valid, locked, cycle_slip;
   logic [5:0] err;
   int         checks = 0;
   int         errors = 0;

`ifdef PFD_DEADZONE_EN
   localparam bit DZ_ON = 1'b1;
`else
   localparam bit DZ_ON = 1'b0;
`endif

   pfd_tdc #(
      .SYNC_STAGES(2), .ERR_W(6), .LOCK_TOL(2), .LOCK_CNT(4), .DEADZONE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clk_ref(clk_ref), .clk_fb(clk_fb),
      .up(up), .down(down), .err_valid(err_valid), .err(err),
      .locked(locked), .cycle_slip(cycle_slip)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int model_err(input int e);
      if (DZ_ON && (e <= 1) && (e >= -1)) return 0;
      return e;
   endfunction

   function automatic int err_int();
      return int'($signed(err));
   endfunction

   // Leading input rises, trailing input rises gap cycles later; checks the result.
   task automatic run_cmp(input string tag, input bit ref_first, input int gap, input int exp_err);
      int ups, downs, slips;
      bit got;
      ups = 0; downs = 0; slips = 0; got = 1'b0;
      if (ref_first || gap == 0) clk_ref = 1'b1;
      if (!ref_first || gap == 0) clk_fb = 1'b1;
      for (int i = 0; i < gap; i++) begin
         tick();
         ups += int'(up); downs += int'(down); slips += int'(cycle_slip);
      end
      clk_ref = 1'b1;
      clk_fb  = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         ups += int'(up); downs += int'(down); slips += int'(cycle_slip);
         got = err_valid;
      end
      chk({tag, "_valid"}, int'(got), 1);
      chk({tag, "_err"}, err_int(), exp_err);
      chk({tag, "_upcycles"}, ups, ref_first && gap > 0 ? gap : 0);
      chk({tag, "_downcycles"}, downs, !ref_first && gap > 0 ? gap : 0);
      chk({tag, "_noslip"}, slips, 0);
      tick();
      chk({tag, "_pulse"}, int'(err_valid), 0);
      chk({tag, "_hold"}, err_int(), exp_err);
      clk_ref = 1'b0;
      clk_fb  = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      int slips, upl, bad;
      bit got;
      rst_n = 1'b0; en = 1'b1; clk_ref = 1'b0; clk_fb = 1'b0;
      repeat (2) tick();
      chk("rst_up", int'(up), 0);
      chk("rst_down", int'(down), 0);
      chk("rst_valid", int'(err_valid), 0);
      chk("rst_err", err_int(), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_slip", int'(cycle_slip), 0);
      rst_n = 1'b1;
      repeat (4) tick();

      run_cmp("ref_lead5", 1'b1, 5, 5);
      run_cmp("fb_lead3", 1'b0, 3, -3);
      run_cmp("simult", 1'b1, 0, 0);
      run_cmp("sat100", 1'b1, 100, 31);
      chk("locked_after_sat", int'(locked), 0);

      run_cmp("lock_p1", 1'b1, 1, model_err(1));
      run_cmp("lock_m2", 1'b0, 2, -2);
      run_cmp("lock_0", 1'b1, 0, 0);
      chk("locked_after_3", int'(locked), 0);
      run_cmp("lock_p2", 1'b1, 2, 2);
      chk("locked_after_4", int'(locked), 1);
      run_cmp("oot_p3", 1'b1, 3, 3);
      chk("locked_after_oot", int'(locked), 0);

      for (int i = 0; i < 4; i++) run_cmp("relock", 1'b1, 1, model_err(1));
      chk("relocked", int'(locked), 1);

      // Second ref edge 20 cycles after the first with no fb edge in between.
      slips = 0; upl = 0; got = 1'b0;
      clk_ref = 1'b1;
      repeat (10) tick();
      clk_ref = 1'b0;
      repeat (10) tick();
      chk("slip_up_before", int'(up), 1);
      clk_ref = 1'b1;
      repeat (5) begin
         tick();
         slips += int'(cycle_slip); upl += int'(!up);
      end
      chk("slip_locked_drop", int'(locked), 0);
      clk_fb = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         slips += int'(cycle_slip);
         got = err_valid;
         if (!got) upl += int'(!up);
      end
      chk("slip_count", slips, 1);
      chk("slip_up_held", upl, 0);
      chk("slip_close", int'(got), 1);
      chk("slip_err", err_int(), 25);
      clk_ref = 1'b0; clk_fb = 1'b0;
      repeat (4) tick();

      // Disable in the middle of an open ref-led comparison.
      bad = 0;
      clk_ref = 1'b1;
      repeat (4) tick();
      chk("en_up_open", int'(up), 1);
      en = 1'b0;
      tick();
      chk("en_up_cleared", int'(up), 0);
      clk_fb = 1'b1;
      repeat (6) begin
         tick();
         bad += int'(err_valid) + int'(cycle_slip) + int'(up) + int'(down);
      end
      chk("en_quiet", bad, 0);
      clk_ref = 1'b0; clk_fb = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (3) tick();
      run_cmp("reenable", 1'b1, 2, 2);

      // Asynchronous reset in the middle of an open comparison.
      bad = 0;
      clk_ref = 1'b1;
      repeat (4) tick();
      chk("rstmid_up_open", int'(up), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_up_async", int'(up), 0);
      chk("rstmid_err", err_int(), 0);
      clk_ref = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) begin
         tick();
         bad += int'(err_valid) + int'(up) + int'(down);
      end
      chk("rstmid_quiet", bad, 0);
      run_cmp("post_rst", 1'b0, 4, -4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
